// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file with one write port and two
// independent registered read ports, plus a sequencer that clears the array
// one entry per cycle on request.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   we, w_addr, w_data      write port; ignored while clearing or when w_addr >= DEPTH
//   re_a, r_addr_a          read request port A
//   rd_data_a, rd_valid_a   read data port A, 1-cycle latency; data holds when idle
//   re_b, r_addr_b          read request port B
//   rd_data_b, rd_valid_b   read data port B, 1-cycle latency; data holds when idle
//   clr_req                 start sequential clear of all entries
//   clr_busy                high while the clear sequence runs (exactly DEPTH cycles)
//
// Optional feature (macro REGFILE_ZERO_REG_EN): entry 0 is hardwired to zero.
// Writes to address 0 are dropped and reads of address 0 always return 0.
//
// FSM states:
//   state | meaning
//   IDLE  | normal operation, writes accepted
//   CLEAR | writing zero to entry[cnt_q] each cycle, writes ignored

module regfile_2r1w #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic             re_a,
  input  logic [AW-1:0]    r_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_valid_a,
  input  logic             re_b,
  input  logic [AW-1:0]    r_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid_b,
  input  logic             clr_req,
  output logic             clr_busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

`ifdef REGFILE_ZERO_REG_EN
  localparam logic ZERO_REG = 1'b1;
`else
  localparam logic ZERO_REG = 1'b0;
`endif

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic [WIDTH-1:0] rd_data_a_q, rd_data_b_q;
  logic             rd_valid_a_q, rd_valid_b_q;
  logic [WIDTH-1:0] rd_next_a, rd_next_b;

  // Address maps onto a real entry (DEPTH need not be a power of 2).
  function automatic logic in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < DEPTH_W);
  endfunction

  // Address whose reads and writes are forced to zero by the zero-register option.
  function automatic logic is_zero_reg(input logic [AW-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // Sequencer and the single effective write into the array: either the
  // user write (IDLE) or the clear write (CLEAR). clr_req wins over we.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = w_addr;
    mem_wdata = w_data;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (we && in_range(w_addr) && !is_zero_reg(w_addr)) begin
          mem_we = 1'b1;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Read mux with bypass of the same-cycle array write (user or clear).
  always_comb begin
    rd_next_a = '0;
    if (!in_range(r_addr_a) || is_zero_reg(r_addr_a)) begin
      rd_next_a = '0;
    end else if (mem_we && (mem_waddr == r_addr_a)) begin
      rd_next_a = mem_wdata;
    end else begin
      rd_next_a = mem_q[r_addr_a];
    end
  end

  always_comb begin
    rd_next_b = '0;
    if (!in_range(r_addr_b) || is_zero_reg(r_addr_b)) begin
      rd_next_b = '0;
    end else if (mem_we && (mem_waddr == r_addr_b)) begin
      rd_next_b = mem_wdata;
    end else begin
      rd_next_b = mem_q[r_addr_b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_valid_a_q <= re_a;
      rd_valid_b_q <= re_b;
      if (re_a) begin
        rd_data_a_q <= rd_next_a;
      end
      if (re_b) begin
        rd_data_b_q <= rd_next_b;
      end
      if (mem_we) begin
        mem_q[mem_waddr] <= mem_wdata;
      end
    end
  end

  assign rd_data_a  = rd_data_a_q;
  assign rd_data_b  = rd_data_b_q;
  assign rd_valid_a = rd_valid_a_q;
  assign rd_valid_b = rd_valid_b_q;
  assign clr_busy   = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: a vector table on the default 4x4 instance
// plus hand sequences for reset mid-clear, the zero-register option and
// out-of-range addressing / clear length on a DEPTH=6 instance.

module tb_regfile_2r1w;

`ifdef REGFILE_ZERO_REG_EN
  localparam int ZR = 1;
`else
  localparam int ZR = 0;
`endif
  // Expected content of entry 0 after writing 0xF / 0xE to it.
  localparam int F0 = (ZR != 0) ? 0 : 15;
  localparam int E0 = (ZR != 0) ? 0 : 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       we = 1'b0, re_a = 1'b0, re_b = 1'b0, clr_req = 1'b0;
  logic [1:0] w_addr = '0, r_addr_a = '0, r_addr_b = '0;
  logic [3:0] w_data = '0;
  logic [3:0] rd_data_a, rd_data_b;
  logic       rd_valid_a, rd_valid_b, clr_busy;

  logic       we6 = 1'b0, re_a6 = 1'b0, re_b6 = 1'b0, clr6 = 1'b0;
  logic [2:0] wa6 = '0, ra6 = '0, rb6 = '0;
  logic [3:0] wd6 = '0;
  logic [3:0] rda6, rdb6;
  logic       rva6, rvb6, busy6;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .we(we), .w_addr(w_addr), .w_data(w_data),
    .re_a(re_a), .r_addr_a(r_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .re_b(re_b), .r_addr_b(r_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_2r1w #(.WIDTH(4), .DEPTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .we(we6), .w_addr(wa6), .w_data(wd6),
    .re_a(re_a6), .r_addr_a(ra6), .rd_data_a(rda6), .rd_valid_a(rva6),
    .re_b(re_b6), .r_addr_b(rb6), .rd_data_b(rdb6), .rd_valid_b(rvb6),
    .clr_req(clr6), .clr_busy(busy6)
  );

  typedef struct packed {
    logic       we;
    logic [1:0] wa;
    logic [3:0] wd;
    logic       rea;
    logic [1:0] ra;
    logic       reb;
    logic [1:0] rb;
    logic       clr;
    logic       va;
    logic [3:0] da;
    logic       vb;
    logic [3:0] db;
    logic       busy;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(int we_v, int wa, int wd, int rea, int ra, int reb, int rb,
                              int clr, int va, int da, int vb, int db, int busy);
    vec_t v;
    v.we   = 1'(we_v);
    v.wa   = 2'(wa);
    v.wd   = 4'(wd);
    v.rea  = 1'(rea);
    v.ra   = 2'(ra);
    v.reb  = 1'(reb);
    v.rb   = 2'(rb);
    v.clr  = 1'(clr);
    v.va   = 1'(va);
    v.da   = 4'(da);
    v.vb   = 1'(vb);
    v.db   = 4'(db);
    v.busy = 1'(busy);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; w_addr = '0; w_data = '0;
    re_a = 1'b0; r_addr_a = '0; re_b = 1'b0; r_addr_b = '0; clr_req = 1'b0;
  endtask

  initial begin
    int n;

    //            we wa wd rea ra reb rb clr | va da vb db busy
    vecs[0]  = mk(1, 1, 10, 0, 0, 0, 0, 0,  0,  0, 0,  0, 0);
    vecs[1]  = mk(1, 3,  5, 0, 0, 0, 0, 0,  0,  0, 0,  0, 0);
    vecs[2]  = mk(0, 0,  0, 1, 1, 1, 3, 0,  1, 10, 1,  5, 0);
    vecs[3]  = mk(1, 2,  3, 0, 0, 0, 0, 0,  0, 10, 0,  5, 0);
    vecs[4]  = mk(0, 0,  0, 1, 2, 0, 0, 0,  1,  3, 0,  5, 0);
    vecs[5]  = mk(1, 2, 12, 1, 2, 1, 2, 0,  1, 12, 1, 12, 0);
    vecs[6]  = mk(0, 0,  0, 1, 2, 1, 1, 0,  1, 12, 1, 10, 0);
    vecs[7]  = mk(1, 0, 15, 0, 0, 1, 0, 0,  0, 12, 1, F0, 0);
    vecs[8]  = mk(1, 1, 15, 0, 0, 0, 0, 0,  0, 12, 0, F0, 0);
    vecs[9]  = mk(1, 2, 15, 0, 0, 0, 0, 0,  0, 12, 0, F0, 0);
    vecs[10] = mk(1, 3, 15, 1, 3, 0, 0, 0,  1, 15, 0, F0, 0);
    // clear of a full array; entry 3 stays 0xF until the 4th clear cycle
    vecs[11] = mk(0, 0,  0, 1, 3, 0, 0, 1,  1, 15, 0, F0, 1);
    vecs[12] = mk(0, 0,  0, 1, 3, 1, 0, 0,  1, 15, 1,  0, 1);
    vecs[13] = mk(1, 0,  9, 1, 3, 0, 0, 1,  1, 15, 0,  0, 1);
    vecs[14] = mk(0, 0,  0, 1, 3, 0, 0, 0,  1, 15, 0,  0, 1);
    vecs[15] = mk(0, 0,  0, 1, 3, 0, 0, 0,  1,  0, 0,  0, 0);
    vecs[16] = mk(0, 0,  0, 1, 0, 1, 1, 0,  1,  0, 1,  0, 0);
    vecs[17] = mk(0, 0,  0, 1, 2, 1, 3, 0,  1,  0, 1,  0, 0);
    // clr_req with same-cycle write: write dropped, entry 1 keeps 6 until cleared
    vecs[18] = mk(1, 1,  6, 0, 0, 0, 0, 0,  0,  0, 0,  0, 0);
    vecs[19] = mk(1, 1,  7, 0, 0, 0, 0, 1,  0,  0, 0,  0, 1);
    vecs[20] = mk(0, 0,  0, 1, 1, 0, 0, 0,  1,  6, 0,  0, 1);
    vecs[21] = mk(0, 0,  0, 1, 1, 0, 0, 0,  1,  0, 0,  0, 1);
    vecs[22] = mk(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0,  0, 1);
    vecs[23] = mk(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0,  0, 0);
    vecs[24] = mk(0, 0,  0, 0, 0, 1, 1, 0,  0,  0, 1,  0, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_valid_a", 32'(rd_valid_a), 32'd0);
    chk("reset rd_valid_b", 32'(rd_valid_b), 32'd0);
    chk("reset rd_data_a",  32'(rd_data_a),  32'd0);
    chk("reset rd_data_b",  32'(rd_data_b),  32'd0);
    chk("reset clr_busy",   32'(clr_busy),   32'd0);
    chk("reset busy6",      32'(busy6),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      we = vecs[i].we; w_addr = vecs[i].wa; w_data = vecs[i].wd;
      re_a = vecs[i].rea; r_addr_a = vecs[i].ra;
      re_b = vecs[i].reb; r_addr_b = vecs[i].rb;
      clr_req = vecs[i].clr;
      step();
      chk($sformatf("v%0d rd_valid_a", i), 32'(rd_valid_a), 32'(vecs[i].va));
      chk($sformatf("v%0d rd_data_a", i),  32'(rd_data_a),  32'(vecs[i].da));
      chk($sformatf("v%0d rd_valid_b", i), 32'(rd_valid_b), 32'(vecs[i].vb));
      chk($sformatf("v%0d rd_data_b", i),  32'(rd_data_b),  32'(vecs[i].db));
      chk($sformatf("v%0d clr_busy", i),   32'(clr_busy),   32'(vecs[i].busy));
    end
    idle_inputs();

    // entry 0: ordinary storage, or hardwired zero with the option enabled
    we = 1'b1; w_addr = 2'd0; w_data = 4'hE; re_b = 1'b1; r_addr_b = 2'd0;
    step();
    chk("zero bypass rd_data_b", 32'(rd_data_b), 32'(E0));
    idle_inputs();
    re_a = 1'b1; r_addr_a = 2'd0;
    step();
    chk("zero read rd_data_a", 32'(rd_data_a), 32'(E0));
    idle_inputs();

    // DEPTH=6: out-of-range write ignored, out-of-range read returns 0 with valid
    we6 = 1'b1; wa6 = 3'd6; wd6 = 4'hD;
    step();
    wa6 = 3'd5; wd6 = 4'h9;
    step();
    we6 = 1'b0; re_a6 = 1'b1; ra6 = 3'd7; re_b6 = 1'b1; rb6 = 3'd6;
    step();
    chk("d6 oor rd_valid_a", 32'(rva6), 32'd1);
    chk("d6 oor rd_data_a",  32'(rda6), 32'd0);
    chk("d6 oor rd_valid_b", 32'(rvb6), 32'd1);
    chk("d6 oor rd_data_b",  32'(rdb6), 32'd0);
    re_b6 = 1'b0; ra6 = 3'd5;
    step();
    chk("d6 read 5", 32'(rda6), 32'd9);
    re_a6 = 1'b0; clr6 = 1'b1;
    step();
    clr6 = 1'b0;
    n = 0;
    while (busy6 && n < 20) begin
      n++;
      step();
    end
    chk("d6 clr_busy cycles", 32'(n), 32'd6);
    re_a6 = 1'b1; ra6 = 3'd5;
    step();
    chk("d6 read 5 after clear", 32'(rda6), 32'd0);
    re_a6 = 1'b0;

    // reset asserted in the 2nd cycle of a clear
    we = 1'b1; w_addr = 2'd2; w_data = 4'hB;
    step();
    idle_inputs();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0; re_a = 1'b1; r_addr_a = 2'd0;
    step();
    chk("pre-reset clr_busy",   32'(clr_busy),   32'd1);
    chk("pre-reset rd_valid_a", 32'(rd_valid_a), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("mid-clear reset clr_busy",   32'(clr_busy),   32'd0);
    chk("mid-clear reset rd_valid_a", 32'(rd_valid_a), 32'd0);
    re_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    re_a = 1'b1; r_addr_a = 2'd2;
    step();
    chk("post-reset rd_valid_a", 32'(rd_valid_a), 32'd1);
    chk("post-reset entry 2",    32'(rd_data_a),  32'd0);
    chk("post-reset clr_busy",   32'(clr_busy),   32'd0);
    idle_inputs();
    step();
    chk("post-reset idle rd_valid_a", 32'(rd_valid_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
